plic_target: RTL and testbench



---
 rtl/plic_target.sv | 101 ++++++++++
 tb/tb_plic_target.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/plic_target.sv
// Per-target PLIC core: priority/enable/threshold arbitration over gateway pending
// bits, hart external-interrupt line, and a word-addressed claim/complete register port.
module plic_target #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  ip,
  output logic [N_SRC-1:0]  claim,
  output logic [N_SRC-1:0]  complete,
  output logic              eip,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_rvalid
);

  localparam int unsigned ID_W = $clog2(N_SRC);
  localparam logic [ADDR_W-1:0] A_EN = ADDR_W'(N_SRC);
  localparam logic [ADDR_W-1:0] A_TH = ADDR_W'(N_SRC + 1);
  localparam logic [ADDR_W-1:0] A_CC = ADDR_W'(N_SRC + 2);

  logic [PRIO_W-1:0] prio [N_SRC];
  logic [N_SRC-1:0]  en;
  logic [PRIO_W-1:0] thr;
  logic [1:0]        hold, hold_d;
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;
  logic              claim_fire, comp_fire;
  logic [31:0]       rdata_d;

  // Ascending scan with strict '>' keeps the lowest id on priority ties.
  // en[0] is held at 0, so slot 0 never becomes a candidate.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (ip[i] && en[i] && (prio[i] > thr) && (prio[i] > best_prio_d)) begin
        best_id_d   = ID_W'(i);
        best_prio_d = prio[i];
      end
    end
  end

  assign claim_fire = reg_re && (reg_addr == A_CC) && (hold == 2'd0) && (best_prio_q != '0);
  assign comp_fire  = reg_we && (reg_addr == A_CC) && (reg_wdata != 32'd0)
                      && (reg_wdata < 32'(N_SRC)) && en[reg_wdata[ID_W-1:0]];

  always_comb begin
    if (claim_fire)        hold_d = 2'd2;
    else if (hold != 2'd0) hold_d = hold - 2'd1;
    else                   hold_d = 2'd0;
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 1; i < N_SRC; i++) begin
      if (reg_addr == ADDR_W'(i)) rdata_d[PRIO_W-1:0] = prio[i];
    end
    if (reg_addr == A_EN) rdata_d[N_SRC-1:0] = en;
    if (reg_addr == A_TH) rdata_d[PRIO_W-1:0] = thr;
    if (reg_addr == A_CC && hold == 2'd0) rdata_d[ID_W-1:0] = best_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) prio[i] <= '0;
      en          <= '0;
      thr         <= '0;
      hold        <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      eip         <= 1'b0;
      claim       <= '0;
      complete    <= '0;
      reg_rdata   <= '0;
      reg_rvalid  <= 1'b0;
    end else begin
      if (reg_we) begin
        for (int unsigned i = 1; i < N_SRC; i++) begin
          if (reg_addr == ADDR_W'(i)) prio[i] <= reg_wdata[PRIO_W-1:0];
        end
        if (reg_addr == A_EN) en  <= {reg_wdata[N_SRC-1:1], 1'b0};
        if (reg_addr == A_TH) thr <= reg_wdata[PRIO_W-1:0];
      end
      hold        <= hold_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      eip         <= (best_id_d != '0) && (hold_d == 2'd0);
      claim       <= claim_fire ? (N_SRC'(1) << best_id_q) : '0;
      complete    <= comp_fire ? (N_SRC'(1) << reg_wdata[ID_W-1:0]) : '0;
      reg_rvalid  <= reg_re;
      reg_rdata   <= reg_re ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_plic_target.sv
// Directed bench for plic_target: expected read data queued at issue, compared on rvalid.
module tb_plic_target;

  localparam int unsigned N_SRC = 8;
  localparam logic [5:0] A_EN = 6'd8, A_TH = 6'd9, A_CC = 6'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ip = '0;
  logic [7:0]  claim, complete;
  logic        eip;
  logic        reg_we = 1'b0, reg_re = 1'b0;
  logic [5:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [31:0] exp_q[$];

  plic_target #(.N_SRC(N_SRC), .PRIO_W(3), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .ip(ip), .claim(claim), .complete(complete), .eip(eip),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_read(input string tag);
    chk({tag, "_rvalid"}, {31'd0, reg_rvalid}, 32'd1);
    if (exp_q.size() != 0) chk(tag, reg_rdata, exp_q.pop_front());
    else chk({tag, "_noexp"}, 32'd1, 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] e);
    @(negedge clk);
    reg_re = 1'b1; reg_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    reg_re = 1'b0;
    chk_read(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_eip", {31'd0, eip}, 32'd0);
    chk("rst_claim", {24'd0, claim}, 32'd0);
    chk("rst_complete", {24'd0, complete}, 32'd0);
    chk("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle: everything pending, all priorities zero
    ip = 8'hFE;
    repeat (3) @(negedge clk);
    chk("idle_eip", {31'd0, eip}, 32'd0);
    rd("idle_claim", A_CC, 32'd0);
    chk("idle_claim_pulse", {24'd0, claim}, 32'd0);

    // Priority pick
    wr(6'd3, 32'd5);
    wr(6'd5, 32'd5);
    wr(6'd2, 32'd7);
    wr(A_EN, 32'h2D);
    wr(A_TH, 32'd4);
    wr(6'd0, 32'd7);
    wr(6'd40, 32'hFFFF_FFFF);
    rd("prio2_rb", 6'd2, 32'd7);
    rd("en_rb", A_EN, 32'h2C);
    rd("addr0_rb", 6'd0, 32'd0);
    rd("unmapped_rb", 6'd40, 32'd0);
    ip = 8'h2C;
    repeat (3) @(negedge clk);
    chk("pick_eip", {31'd0, eip}, 32'd1);

    // Back-to-back claim reads: second lands in the hold window
    reg_re = 1'b1; reg_addr = A_CC;
    exp_q.push_back(32'd2);
    @(negedge clk);
    exp_q.push_back(32'd0);
    chk_read("claim_first");
    chk("claim_first_pulse", {24'd0, claim}, 32'h04);
    chk("hold_eip_t1", {31'd0, eip}, 32'd0);
    ip = 8'h28;
    @(negedge clk);
    reg_re = 1'b0;
    chk_read("claim_second");
    chk("claim_second_pulse", {24'd0, claim}, 32'd0);
    chk("hold_eip_t2", {31'd0, eip}, 32'd0);
    @(negedge clk);
    chk("hold_eip_t3", {31'd0, eip}, 32'd1);
    rd("claim_tie", A_CC, 32'd3);
    chk("claim_tie_pulse", {24'd0, claim}, 32'h08);
    @(negedge clk);
    chk("claim_pulse_one_cycle", {24'd0, claim}, 32'd0);
    ip = 8'h20;

    // Threshold gate
    ip = 8'h10;
    wr(A_EN, 32'h10);
    wr(6'd4, 32'd3);
    wr(A_TH, 32'd3);
    repeat (4) @(negedge clk);
    chk("thr_eq_eip", {31'd0, eip}, 32'd0);
    wr(A_TH, 32'd2);
    @(negedge clk);
    chk("thr_lowered_eip", {31'd0, eip}, 32'd1);
    rd("thr_rb", A_TH, 32'd2);

    // Complete rules
    wr(A_CC, 32'd4);
    chk("complete_4", {24'd0, complete}, 32'h10);
    @(negedge clk);
    chk("complete_one_cycle", {24'd0, complete}, 32'd0);
    wr(A_CC, 32'd0);
    chk("complete_id0", {24'd0, complete}, 32'd0);
    wr(A_CC, 32'd8);
    chk("complete_oor", {24'd0, complete}, 32'd0);
    wr(A_CC, 32'h104);
    chk("complete_oor_hi", {24'd0, complete}, 32'd0);
    wr(A_EN, 32'd0);
    wr(A_CC, 32'd4);
    chk("complete_disabled", {24'd0, complete}, 32'd0);

    // Async reset while claim[1] is high
    ip = 8'h02;
    wr(6'd1, 32'd1);
    wr(A_TH, 32'd0);
    wr(A_EN, 32'h02);
    repeat (3) @(negedge clk);
    chk("pre_rst_eip", {31'd0, eip}, 32'd1);
    rd("rst_claim_id", A_CC, 32'd1);
    chk("rst_claim_pulse", {24'd0, claim}, 32'h02);
    #2 rst = 1'b1;
    #1;
    chk("async_claim", {24'd0, claim}, 32'd0);
    chk("async_eip", {31'd0, eip}, 32'd0);
    chk("async_rvalid", {31'd0, reg_rvalid}, 32'd0);
    chk("async_rdata", reg_rdata, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ip = '0;
    rd("post_rst_en", A_EN, 32'd0);
    rd("post_rst_prio1", 6'd1, 32'd0);
    rd("post_rst_thr", A_TH, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
